// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP microcoded control path.
// Holds the control-word width, control-bit positions, opcode values,
// the microstep type, the sequencer state enum and the ROM address helper.
package sap_ctrl_pkg;

  localparam int unsigned CW_WIDTH   = 18;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned STEP_WIDTH = 3;
  localparam int unsigned LAST_STEP  = 4;

  // Control word bit positions
  localparam int unsigned HLT_BIT = 17;
  localparam int unsigned MI_BIT  = 16;
  localparam int unsigned RI_BIT  = 15;
  localparam int unsigned RO_BIT  = 14;
  localparam int unsigned IO_BIT  = 13;
  localparam int unsigned AI_BIT  = 12;
  localparam int unsigned II_BIT  = 11;
  localparam int unsigned AO_BIT  = 10;
  localparam int unsigned SUM_BIT = 9;
  localparam int unsigned SUB_BIT = 8;
  localparam int unsigned BI_BIT  = 7;
  localparam int unsigned OI_BIT  = 6;
  localparam int unsigned CE_BIT  = 5;
  localparam int unsigned CO_BIT  = 4;
  localparam int unsigned J_BIT   = 3;
  localparam int unsigned FI_BIT  = 2;
  localparam int unsigned JC_BIT  = 1;
  localparam int unsigned JZ_BIT  = 0;

  // Opcodes (IR[7:4])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef logic [STEP_WIDTH-1:0] step_t;

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_e;

  // Microcode ROM address: opcode in the upper nibble, microstep below.
  function automatic logic [ADDR_WIDTH-1:0] rom_addr(input logic [3:0] opcode, input step_t step);
    return {opcode, step};
  endfunction

endpackage

// File: rtl/step_sync.sv
// Synchroniser plus rising-edge detector for the asynchronous STEP_REQ button.
// Ports:
//   clk, rst  clock and async active-high reset
//   req       raw asynchronous request
//   pulse_c   one-cycle pulse on the synchronised rising edge (combinational from flops)
module step_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic pulse_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift chain: sync_q[0] is the metastability-exposed flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], req};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: instruction register, microstep counter, halt latch
// and the datapath clock enable (free-run or manual single-step).
// Ports:
//   CLK, RST    clock and async active-high reset
//   MODE        0 free-run, 1 manual single-step
//   STEP_REQ    async push-button, one advance per rising edge in manual mode
//   BUS_IN      system bus, loaded into IR when the word asserts II
//   CTRL_WORD   microcode ROM data for the current ADDRESS
//   ADDRESS     {IR[7:4], STEP} to the ROM
//   CTRL_OUT    control word to the datapath, zeroed when halted or step illegal
//   CLK_EN      datapath enable, high in the cycle the sequencer advances
//   IR_OPERAND  IR[3:0]
//   STEP        current microstep
//   HALTED      halt latch
module control_sequencer #(
  parameter int unsigned CW_WIDTH    = sap_ctrl_pkg::CW_WIDTH,
  parameter int unsigned LAST_STEP   = sap_ctrl_pkg::LAST_STEP,
  parameter int unsigned HLT_BIT     = sap_ctrl_pkg::HLT_BIT,
  parameter int unsigned II_BIT      = sap_ctrl_pkg::II_BIT,
  parameter int unsigned EARLY_END   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                MODE,
  input  logic                STEP_REQ,
  input  logic [7:0]          BUS_IN,
  input  logic [CW_WIDTH-1:0] CTRL_WORD,
  output logic [6:0]          ADDRESS,
  output logic [CW_WIDTH-1:0] CTRL_OUT,
  output logic                CLK_EN,
  output logic [3:0]          IR_OPERAND,
  output logic [2:0]          STEP,
  output logic                HALTED
);

  import sap_ctrl_pkg::*;

  seq_state_e          state_q, state_d;
  step_t               step_q, step_d;
  logic [7:0]          ir_q, ir_d;
  logic                rst_q;
  logic                pulse_c;
  logic                clk_en_c;
  logic                step_legal_c;
  logic [CW_WIDTH-1:0] ctrl_out_c;

  step_sync #(.STAGES(SYNC_STAGES)) u_step_sync (
    .clk     (CLK),
    .rst     (RST),
    .req     (STEP_REQ),
    .pulse_c (pulse_c)
  );

  // Holds the enable off for the first cycle after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rst_q <= 1'b1;
    else     rst_q <= 1'b0;
  end

  // Sequencer state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= SEQ_RUN;
      step_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ir_q    <= ir_d;
    end
  end

  assign step_legal_c = (step_q <= STEP_WIDTH'(LAST_STEP));
  assign clk_en_c     = (state_q == SEQ_RUN) && !rst_q && (MODE ? pulse_c : 1'b1);
  // Out-of-range steps read undefined ROM rows, so the word is masked there.
  assign ctrl_out_c   = (step_legal_c && (state_q == SEQ_RUN)) ? CTRL_WORD : '0;

  // Next-state: IR load, halt entry and microstep advance
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ir_d    = ir_q;
    case (state_q)
      SEQ_RUN: begin
        if (clk_en_c) begin
          if (ctrl_out_c[II_BIT]) ir_d = BUS_IN;
          if (ctrl_out_c[HLT_BIT]) begin
            state_d = SEQ_HALT;
          end else if (step_q >= STEP_WIDTH'(LAST_STEP)) begin
            step_d = '0;
          end else if ((EARLY_END != 0) && (step_q >= STEP_WIDTH'(2)) && (CTRL_WORD == '0)) begin
            step_d = '0;
          end else begin
            step_d = step_q + STEP_WIDTH'(1);
          end
        end
      end
      SEQ_HALT: begin
        state_d = SEQ_HALT;
      end
      default: begin
        state_d = SEQ_RUN;
      end
    endcase
  end

  assign ADDRESS    = rom_addr(ir_q[7:4], step_q);
  assign CTRL_OUT   = ctrl_out_c;
  assign CLK_EN     = clk_en_c;
  assign IR_OPERAND = ir_q[3:0];
  assign STEP       = step_q;
  assign HALTED     = (state_q == SEQ_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (early end on/off) share one
// microcode ROM table and inputs; a cycle-level reference model predicts all
// outputs, plus directed checks for fetch, full/early length, halt, manual step.
module tb_control_sequencer;
  import sap_ctrl_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam logic [17:0] W_F0  = (18'd1 << CO_BIT) | (18'd1 << MI_BIT);
  localparam logic [17:0] W_F1  = (18'd1 << RO_BIT) | (18'd1 << II_BIT) | (18'd1 << CE_BIT);
  localparam logic [17:0] W_HLT = 18'd1 << HLT_BIT;

  logic        CLK = 1'b0;
  logic        RST, MODE, STEP_REQ;
  logic [7:0]  BUS_IN;
  logic [17:0] rom [128];
  logic [17:0] cw [2];
  logic [6:0]  address [2];
  logic [17:0] ctrl_out [2];
  logic        clk_en [2];
  logic [3:0]  ir_operand [2];
  logic [2:0]  step [2];
  logic        halted [2];

  logic        nx_rst, nx_mode, nx_req;
  logic [7:0]  nx_bus;

  // Reference model state
  logic [7:0]  m_ir [2];
  logic [2:0]  m_step [2];
  logic        m_halt [2];
  logic        m_rstq;
  logic [SYNC:0] hist;

  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  assign cw[0] = rom[address[0]];
  assign cw[1] = rom[address[1]];

  control_sequencer #(.EARLY_END(1)) dut_ee (
    .CLK(CLK), .RST(RST), .MODE(MODE), .STEP_REQ(STEP_REQ), .BUS_IN(BUS_IN),
    .CTRL_WORD(cw[0]), .ADDRESS(address[0]), .CTRL_OUT(ctrl_out[0]), .CLK_EN(clk_en[0]),
    .IR_OPERAND(ir_operand[0]), .STEP(step[0]), .HALTED(halted[0])
  );

  control_sequencer #(.EARLY_END(0)) dut_ne (
    .CLK(CLK), .RST(RST), .MODE(MODE), .STEP_REQ(STEP_REQ), .BUS_IN(BUS_IN),
    .CTRL_WORD(cw[1]), .ADDRESS(address[1]), .CTRL_OUT(ctrl_out[1]), .CLK_EN(clk_en[1]),
    .IR_OPERAND(ir_operand[1]), .STEP(step[1]), .HALTED(halted[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fill the ROM: common fetch, NOP empty, HLT at step 2, other ops random.
  task automatic set_rom(input bit rnd);
    logic [17:0] mask, w;
    logic [3:0]  op;
    logic [2:0]  s;
    logic [6:0]  a;
    mask = rnd ? ~W_HLT : ~(W_HLT | (18'd1 << II_BIT));
    for (int i = 0; i < 128; i++) begin
      a  = 7'(i);
      op = a[6:3];
      s  = a[2:0];
      if (s == 3'd0)      w = W_F0;
      else if (s == 3'd1) w = W_F1;
      else if (s > 3'd4)  w = 18'($urandom);
      else if (op == OP_NOP) w = '0;
      else if (op == OP_HLT) w = (s == 3'd2) ? W_HLT : '0;
      else begin
        w = 18'($urandom) & mask;
        if (rnd && ($urandom_range(2) == 0)) w = '0;
        else if (w == '0) w = 18'd1 << AI_BIT;
      end
      rom[i] = w;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ir[i] = '0; m_step[i] = '0; m_halt[i] = 1'b0;
    end
    m_rstq = 1'b1;
    hist   = '0;
  endtask

  // One clock: apply inputs at negedge, check against model, advance model.
  task automatic cycle();
    logic [17:0] word, co;
    logic        pulse, en;
    @(negedge CLK);
    RST = nx_rst; MODE = nx_mode; STEP_REQ = nx_req; BUS_IN = nx_bus;
    #1;
    if (RST) model_reset();
    pulse = hist[SYNC-1] & ~hist[SYNC];
    for (int i = 0; i < 2; i++) begin
      word = rom[{m_ir[i][7:4], m_step[i]}];
      co   = (m_step[i] <= 3'd4 && !m_halt[i]) ? word : 18'd0;
      en   = !m_halt[i] && !m_rstq && (MODE ? pulse : 1'b1);
      check($sformatf("address%0d", i), 32'(address[i]), 32'({m_ir[i][7:4], m_step[i]}));
      check($sformatf("ctrl_out%0d", i), 32'(ctrl_out[i]), 32'(co));
      check($sformatf("clk_en%0d", i), 32'(clk_en[i]), 32'(en));
      check($sformatf("step%0d", i), 32'(step[i]), 32'(m_step[i]));
      check($sformatf("halted%0d", i), 32'(halted[i]), 32'(m_halt[i]));
      check($sformatf("operand%0d", i), 32'(ir_operand[i]), 32'(m_ir[i][3:0]));
      if (!RST && en) begin
        if (co[II_BIT]) m_ir[i] = BUS_IN;
        if (co[HLT_BIT]) m_halt[i] = 1'b1;
        else if (m_step[i] >= 3'd4) m_step[i] = 3'd0;
        else if (i == 0 && m_step[i] >= 3'd2 && word == 18'd0) m_step[i] = 3'd0;
        else m_step[i] = m_step[i] + 3'd1;
      end
    end
    if (!RST) begin
      m_rstq = 1'b0;
      hist   = {hist[SYNC-1:0], STEP_REQ};
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic reset_seq();
    nx_rst = 1'b1;
    cycle();
    for (int i = 0; i < 2; i++) begin
      check("rst_step", 32'(step[i]), 32'(0));
      check("rst_addr", 32'(address[i]), 32'(7'h00));
      check("rst_halt", 32'(halted[i]), 32'(0));
      check("rst_clken", 32'(clk_en[i]), 32'(0));
    end
    cycle();
    nx_rst = 1'b0;
    cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] seq_ee [6];
    logic [2:0] seq_ne [6];
    logic [2:0] prev;
    int adv, adv_at, k;

    nx_rst = 1'b1; nx_mode = 1'b0; nx_req = 1'b0; nx_bus = 8'h00;
    RST = 1'b1; MODE = 1'b0; STEP_REQ = 1'b0; BUS_IN = 8'h00;
    model_reset();
    set_rom(1'b0);
    reset_seq();

    // Fetch of 0x1E: IR loads at the step-1 edge
    nx_bus = 8'h1E;
    cycle(); cycle();
    check("fetch_addr", 32'(address[0]), 32'(7'b0001_010));
    check("fetch_operand", 32'(ir_operand[0]), 32'(4'hE));
    repeat (3) cycle();

    // Full-length ADD
    nx_bus = 8'h2A;
    seq_ee = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int j = 0; j < 6; j++) begin
      check("add_step", 32'(step[0]), 32'(seq_ee[j]));
      if (j >= 2) check("add_operand", 32'(ir_operand[0]), 32'(4'hA));
      if (j < 5) cycle();
    end

    // NOP: early end vs full length
    nx_bus = 8'h05;
    seq_ee = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    seq_ne = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int j = 0; j < 6; j++) begin
      check("nop_step_ee", 32'(step[0]), 32'(seq_ee[j]));
      check("nop_step_ne", 32'(step[1]), 32'(seq_ne[j]));
      if (j < 5) cycle();
    end

    // Reset mid-step 3
    nx_bus = 8'h2A;
    k = 0;
    while (step[0] != 3'd3 && k < 12) begin
      cycle();
      k++;
    end
    check("reach_step3", 32'(step[0]), 32'(3));
    reset_seq();

    // Halt on opcode F step 2
    nx_bus = 8'hF0;
    repeat (3) cycle();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 2; i++) begin
        check("halt_flag", 32'(halted[i]), 32'(1));
        check("halt_step", 32'(step[i]), 32'(2));
        check("halt_ctrl", 32'(ctrl_out[i]), 32'(0));
      end
      nx_mode = 1'b1;
      for (int c = 0; c < 20; c++) begin
        nx_req = c[1];
        cycle();
      end
    end
    nx_mode = 1'b0; nx_req = 1'b0;
    reset_seq();

    // Manual single-step
    nx_mode = 1'b1;
    nx_bus  = 8'h2A;
    repeat (5) cycle();
    check("man_idle", 32'(step[0]), 32'(0));
    nx_req = 1'b1;
    adv = 0; adv_at = 0;
    for (int c = 1; c <= 10; c++) begin
      prev = step[0];
      cycle();
      if (step[0] != prev) begin
        adv++;
        adv_at = c;
      end
    end
    check("man_one_adv", 32'(adv), 32'(1));
    check("man_latency", 32'(adv_at >= 2 && adv_at <= 3), 32'(1));
    nx_req = 1'b0;
    repeat (5) cycle();
    check("man_hold", 32'(step[0]), 32'(1));
    nx_req = 1'b1;
    repeat (4) cycle();
    check("man_second", 32'(step[0]), 32'(2));
    nx_req = 1'b0;

    // Randomised run with random microcode
    set_rom(1'b1);
    nx_mode = 1'b0;
    reset_seq();
    for (int c = 0; c < 1500; c++) begin
      nx_rst = ($urandom_range(79) == 0);
      if ($urandom_range(24) == 0) nx_mode = ~nx_mode;
      if ($urandom_range(2) == 0) nx_req = ~nx_req;
      nx_bus = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
